// File: rtl/fp_gray_sum_pkg.sv
// ============================================================================
// gray_sum_pkg : shared types and constants for the fp_gray_sum datapath
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package gray_sum_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ALIGN = 3'd2,
        ADD   = 3'd3,
        NORM  = 3'd4,
        TOINT = 3'd5,
        DONE  = 3'd6
    } state_t;

    localparam logic [31:0] DEF_RED_CONSTANT   = 32'h3e99096c;
    localparam logic [31:0] DEF_GREEN_CONSTANT = 32'h3f1645a2;
    localparam logic [31:0] DEF_BLUE_CONSTANT  = 32'h3de978d5;
    localparam int          DEF_BIAS           = 127;

    localparam int ACC_M_W = 25;
    localparam int ACC_E_W = 10;
    localparam int DIFF_W  = ACC_E_W + 1;
    localparam int CNT_W   = 5;

    localparam logic signed [ACC_E_W-1:0] ACC_E_ONE = 1;
    localparam logic signed [DIFF_W-1:0]  DIFF_ONE  = 1;
    localparam logic signed [DIFF_W-1:0]  MAX_SHIFT = 24;

    // Unbiased exponent of a rebuilt channel product
    function automatic logic signed [ACC_E_W-1:0] prod_exp(input int pix_exp, input int k_exp,
                                                           input int shift, input int bias);
        int e;
        e = pix_exp + k_exp - 2 * bias + 1 - shift;
        return ACC_E_W'(e);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp_add_iter.sv
// ============================================================================
// fp_add_iter : iterative align/add/normalize of two positive floats
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_add_iter
    import gray_sum_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      start,
    input  logic [ACC_M_W-1:0]        a_m,
    input  logic signed [ACC_E_W-1:0] a_e,
    input  logic [ACC_M_W-1:0]        b_m,
    input  logic signed [ACC_E_W-1:0] b_e,
    output logic                      done,
    output logic [ACC_M_W-1:0]        sum_m,
    output logic signed [ACC_E_W-1:0] sum_e
);

    state_t                      state, next_state;
    logic [ACC_M_W-1:0]          acc_m, op_m;
    logic signed [ACC_E_W-1:0]   acc_e, op_e;
    logic signed [DIFF_W-1:0]    diff;
    logic                        align_last;

    assign diff = {acc_e[ACC_E_W-1], acc_e} - {op_e[ACC_E_W-1], op_e};

    // ALIGN ends on the cycle whose shift makes the exponents equal
    assign align_last = (acc_m == '0) || (op_m == '0) || (diff == '0) ||
                        (diff == DIFF_ONE) || (diff == -DIFF_ONE) ||
                        (diff > MAX_SHIFT) || (diff < -MAX_SHIFT);

    assign sum_m = acc_m[ACC_M_W-1] ? (acc_m >> 1) : acc_m;
    assign sum_e = acc_m[ACC_M_W-1] ? (acc_e + ACC_E_ONE) : acc_e;
    assign done  = (state == NORM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (en) begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = ALIGN;
            ALIGN:   if (align_last) next_state = ADD;
            ADD:     next_state = NORM;
            NORM:    next_state = start ? ALIGN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_m <= '0;
            acc_e <= '0;
            op_m  <= '0;
            op_e  <= '0;
        end else if (en) begin
            if (start && (state == IDLE || state == NORM)) begin
                acc_m <= a_m;
                acc_e <= a_e;
                op_m  <= b_m;
                op_e  <= b_e;
            end else begin
                case (state)
                    ALIGN: begin
                        if (op_m != '0) begin
                            if (acc_m == '0) begin
                                acc_e <= op_e;
                            end else if (diff > MAX_SHIFT) begin
                                op_m <= '0;
                            end else if (diff < -MAX_SHIFT) begin
                                acc_m <= '0;
                                acc_e <= op_e;
                            end else if (diff > 0) begin
                                op_m <= op_m >> 1;
                                op_e <= op_e + ACC_E_ONE;
                            end else if (diff < 0) begin
                                acc_m <= acc_m >> 1;
                                acc_e <= acc_e + ACC_E_ONE;
                            end
                        end
                    end
                    ADD: acc_m <= acc_m + op_m;
                    NORM: begin
                        acc_m <= sum_m;
                        acc_e <= sum_e;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fp_gray_sum.sv
// ============================================================================
// fp_gray_sum : weighted RGB float sum converted to a rounded 8-bit gray pixel
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_gray_sum
    import gray_sum_pkg::*;
#(
    parameter logic [31:0] RED_CONSTANT   = DEF_RED_CONSTANT,
    parameter logic [31:0] GREEN_CONSTANT = DEF_GREEN_CONSTANT,
    parameter logic [31:0] BLUE_CONSTANT  = DEF_BLUE_CONSTANT,
    parameter int          PIXEL_WIDTH    = 8,
    parameter int          MANTISSA_WIDTH = 23,
    parameter int          EXPONENT_WIDTH = 8,
    parameter int          BIAS           = DEF_BIAS
)(
    input  logic                      clk_i_gray_sum,
    input  logic                      rstn_i_gray_sum,
    input  logic                      en_i_gray_sum,
    input  logic                      mult_done_i,
    input  logic [MANTISSA_WIDTH:0]   mant_R_i,
    input  logic [MANTISSA_WIDTH:0]   mant_G_i,
    input  logic [MANTISSA_WIDTH:0]   mant_B_i,
    input  logic [4:0]                shift_R_i,
    input  logic [4:0]                shift_G_i,
    input  logic [4:0]                shift_B_i,
    input  logic [EXPONENT_WIDTH-1:0] pix_exp_R_i,
    input  logic [EXPONENT_WIDTH-1:0] pix_exp_G_i,
    input  logic [EXPONENT_WIDTH-1:0] pix_exp_B_i,
    input  logic                      pix_zero_R_i,
    input  logic                      pix_zero_G_i,
    input  logic                      pix_zero_B_i,
    output logic [PIXEL_WIDTH-1:0]    gray_o,
    output logic                      gray_valid_o,
    output logic                      busy_o
);

    localparam logic signed [ACC_E_W-1:0] E_SAT = ACC_E_W'(PIXEL_WIDTH);
    localparam logic signed [ACC_E_W-1:0] E_MIN = -1;

    state_t                      state, next_state;
    logic                        done_q, start_edge, pass;
    logic [MANTISSA_WIDTH:0]     mant_r, mant_g, mant_b;
    logic [4:0]                  shift_r, shift_g, shift_b;
    logic [EXPONENT_WIDTH-1:0]   pexp_r, pexp_g, pexp_b;
    logic                        zero_r, zero_g, zero_b;
    logic signed [ACC_E_W-1:0]   e_r, e_g, e_b;

    logic                        add_start, add_done;
    logic [ACC_M_W-1:0]          add_a_m, add_b_m, sum_m;
    logic signed [ACC_E_W-1:0]   add_a_e, add_b_e, sum_e;

    logic [ACC_M_W-1:0]          tm;
    logic [CNT_W-1:0]            cnt;
    logic                        rnd, sat, zero_res, to_finish;
    logic [PIXEL_WIDTH:0]        rounded;
    logic [PIXEL_WIDTH-1:0]      result;

    // Edge register resets high so a level still present after reset is not a start
    assign start_edge = mult_done_i & ~done_q;

    assign e_r = prod_exp(int'(pexp_r), int'(RED_CONSTANT[MANTISSA_WIDTH +: EXPONENT_WIDTH]),
                          int'(shift_r), BIAS);
    assign e_g = prod_exp(int'(pexp_g), int'(GREEN_CONSTANT[MANTISSA_WIDTH +: EXPONENT_WIDTH]),
                          int'(shift_g), BIAS);
    assign e_b = prod_exp(int'(pexp_b), int'(BLUE_CONSTANT[MANTISSA_WIDTH +: EXPONENT_WIDTH]),
                          int'(shift_b), BIAS);

    assign rounded   = {1'b0, tm[PIXEL_WIDTH-1:0]} + {{PIXEL_WIDTH{1'b0}}, rnd};
    assign to_finish = sat | zero_res | (cnt == '0);
    assign result    = sat      ? '1 :
                       zero_res ? '0 :
                       rounded[PIXEL_WIDTH] ? '1 : rounded[PIXEL_WIDTH-1:0];

    assign gray_valid_o = (state == DONE);
    assign busy_o       = (state != IDLE);

    fp_add_iter u_add (
        .clk   (clk_i_gray_sum),
        .rst_n (rstn_i_gray_sum),
        .en    (en_i_gray_sum),
        .start (add_start),
        .a_m   (add_a_m),
        .a_e   (add_a_e),
        .b_m   (add_b_m),
        .b_e   (add_b_e),
        .done  (add_done),
        .sum_m (sum_m),
        .sum_e (sum_e)
    );

    always_ff @(posedge clk_i_gray_sum or negedge rstn_i_gray_sum) begin
        if (!rstn_i_gray_sum) begin
            state <= IDLE;
        end else if (en_i_gray_sum) begin
            state <= next_state;
        end
    end

    // The adder runs while the top sits in ALIGN; its done chains the B pass
    always_comb begin
        next_state = state;
        add_start  = 1'b0;
        add_a_m    = '0;
        add_a_e    = '0;
        add_b_m    = '0;
        add_b_e    = '0;
        case (state)
            IDLE: if (start_edge) next_state = LOAD;
            LOAD: begin
                add_start  = 1'b1;
                add_a_m    = zero_r ? '0 : ACC_M_W'(mant_r);
                add_a_e    = e_r;
                add_b_m    = zero_g ? '0 : ACC_M_W'(mant_g);
                add_b_e    = e_g;
                next_state = ALIGN;
            end
            ALIGN: begin
                if (add_done) begin
                    if (!pass) begin
                        add_start = 1'b1;
                        add_a_m   = sum_m;
                        add_a_e   = sum_e;
                        add_b_m   = zero_b ? '0 : ACC_M_W'(mant_b);
                        add_b_e   = e_b;
                    end else begin
                        next_state = TOINT;
                    end
                end
            end
            TOINT:   if (to_finish) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i_gray_sum or negedge rstn_i_gray_sum) begin
        if (!rstn_i_gray_sum) begin
            done_q   <= 1'b1;
            pass     <= 1'b0;
            mant_r   <= '0;
            mant_g   <= '0;
            mant_b   <= '0;
            shift_r  <= '0;
            shift_g  <= '0;
            shift_b  <= '0;
            pexp_r   <= '0;
            pexp_g   <= '0;
            pexp_b   <= '0;
            zero_r   <= 1'b0;
            zero_g   <= 1'b0;
            zero_b   <= 1'b0;
            tm       <= '0;
            cnt      <= '0;
            rnd      <= 1'b0;
            sat      <= 1'b0;
            zero_res <= 1'b0;
            gray_o   <= '0;
        end else if (en_i_gray_sum) begin
            done_q <= mult_done_i;
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        pass    <= 1'b0;
                        mant_r  <= mant_R_i;
                        mant_g  <= mant_G_i;
                        mant_b  <= mant_B_i;
                        shift_r <= shift_R_i;
                        shift_g <= shift_G_i;
                        shift_b <= shift_B_i;
                        pexp_r  <= pix_exp_R_i;
                        pexp_g  <= pix_exp_G_i;
                        pexp_b  <= pix_exp_B_i;
                        zero_r  <= pix_zero_R_i;
                        zero_g  <= pix_zero_G_i;
                        zero_b  <= pix_zero_B_i;
                    end
                end
                ALIGN: begin
                    if (add_done) begin
                        if (!pass) begin
                            pass <= 1'b1;
                        end else begin
                            tm       <= sum_m;
                            cnt      <= CNT_W'(MANTISSA_WIDTH - int'(sum_e));
                            rnd      <= 1'b0;
                            sat      <= (sum_e >= E_SAT);
                            zero_res <= (sum_e < E_MIN) || (sum_m == '0);
                        end
                    end
                end
                TOINT: begin
                    if (to_finish) begin
                        gray_o <= result;
                    end else begin
                        rnd <= tm[0];
                        tm  <= tm >> 1;
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fp_gray_sum.sv
// ============================================================================
// tb_fp_gray_sum : table-driven scoreboard bench for fp_gray_sum
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_gray_sum;

    localparam logic [31:0] K_R = 32'h3e99096c;
    localparam logic [31:0] K_G = 32'h3f1645a2;
    localparam logic [31:0] K_B = 32'h3de978d5;

    typedef struct {
        int r;
        int g;
        int b;
        int exp_gray;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, en, mult_done;
    logic [23:0] mant_r, mant_g, mant_b;
    logic [4:0]  shift_r, shift_g, shift_b;
    logic [7:0]  pexp_r, pexp_g, pexp_b;
    logic        pz_r, pz_g, pz_b;
    logic [7:0]  gray;
    logic        gray_valid, busy;

    int          checks = 0;
    int          failures = 0;
    int          cycle = 0;
    int          valid_count = 0;
    int          last_valid_cycle = 0;
    int          start_cycle = 0;
    int          base = 0;
    logic [7:0]  exp_q[$];
    vec_t        vecs[16];

    always #5 clk = ~clk;
    always @(posedge clk) cycle = cycle + 1;

    fp_gray_sum dut (
        .clk_i_gray_sum  (clk),
        .rstn_i_gray_sum (rst_n),
        .en_i_gray_sum   (en),
        .mult_done_i     (mult_done),
        .mant_R_i        (mant_r),
        .mant_G_i        (mant_g),
        .mant_B_i        (mant_b),
        .shift_R_i       (shift_r),
        .shift_G_i       (shift_g),
        .shift_B_i       (shift_b),
        .pix_exp_R_i     (pexp_r),
        .pix_exp_G_i     (pexp_g),
        .pix_exp_B_i     (pexp_b),
        .pix_zero_R_i    (pz_r),
        .pix_zero_G_i    (pz_g),
        .pix_zero_B_i    (pz_b),
        .gray_o          (gray),
        .gray_valid_o    (gray_valid),
        .busy_o          (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Scoreboard: every valid pulse pops the oldest expected pixel
    always @(negedge clk) begin
        if (rst_n === 1'b1 && gray_valid === 1'b1) begin
            valid_count++;
            last_valid_cycle = cycle;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_valid: got gray %0d with no pending request", gray);
            end else begin
                check("gray", {24'b0, gray}, {24'b0, exp_q.pop_front()});
            end
        end
    end

    // Reference for the upstream multiplier: integer pixel as float times weight
    task automatic mult_model(input int p, input logic [31:0] k, output logic [23:0] m,
                              output logic [4:0] s, output logic [7:0] pe, output logic z);
        logic [23:0] pm;
        logic [47:0] prod;
        int          e;
        if (p == 0) begin
            m = '0; s = '0; pe = '0; z = 1'b1;
            return;
        end
        e = 0;
        while ((p >> (e + 1)) != 0) e++;
        pm   = 24'(p) << (23 - e);
        prod = {24'b0, pm} * {24'b0, 1'b1, k[22:0]};
        if (prod[47]) begin
            m = prod[47:24]; s = 5'd0;
        end else begin
            m = prod[46:23]; s = 5'd1;
        end
        pe = 8'(127 + e);
        z  = 1'b0;
    endtask

    task automatic apply_pixels(input int r, input int g, input int b);
        mult_model(r, K_R, mant_r, shift_r, pexp_r, pz_r);
        mult_model(g, K_G, mant_g, shift_g, pexp_g, pz_g);
        mult_model(b, K_B, mant_b, shift_b, pexp_b, pz_b);
    endtask

    task automatic start_vec(input int r, input int g, input int b, input int expv);
        apply_pixels(r, g, b);
        @(posedge clk); #1;
        mult_done = 1'b1;
        exp_q.push_back(8'(expv));
        start_cycle = cycle;
        base = valid_count;
    endtask

    task automatic wait_result(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 150 && !seen; i++) begin
            @(negedge clk); #1;
            if (valid_count > base) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: no gray_valid_o within 150 cycles, required 1 pulse", name);
            exp_q.delete();
        end
    endtask

    task automatic finish_vec();
        @(posedge clk); #1;
        mult_done = 1'b0;
        @(negedge clk); #1;
        check("busy_after_done", {31'b0, busy}, 0);
        check("valid_single_pulse", {31'b0, gray_valid}, 0);
    endtask

    int lat1, lat2;

    initial begin
        vecs[0]  = '{255, 255, 255, 255};
        vecs[1]  = '{255,   0,   0,  76};
        vecs[2]  = '{  0,   0, 255,  29};
        vecs[3]  = '{100,   0,   0,  30};
        vecs[4]  = '{  0, 200,   0, 117};
        vecs[5]  = '{  0,   0,   0,   0};
        vecs[6]  = '{ 10,  20,  30,  18};
        vecs[7]  = '{128,  64,  32,  79};
        vecs[8]  = '{  1,   0,   0,   0};
        vecs[9]  = '{  2,   0,   0,   1};
        vecs[10] = '{  3,   0,   0,   1};
        vecs[11] = '{200, 200, 200, 200};
        vecs[12] = '{  0, 255, 255, 179};
        vecs[13] = '{255, 255,   0, 226};
        vecs[14] = '{1000,  0,   0, 255};
        vecs[15] = '{855,   0,   0, 255};

        rst_n = 1'b0; en = 1'b1; mult_done = 1'b0;
        apply_pixels(0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_gray", {24'b0, gray}, 0);
        check("reset_valid", {31'b0, gray_valid}, 0);
        check("reset_busy", {31'b0, busy}, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 16; i++) begin
            start_vec(vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].exp_gray);
            wait_result("vec");
            finish_vec();
        end

        // Level held high: exactly one result, then a fresh edge gives another
        start_vec(255, 0, 0, 76);
        repeat (200) @(negedge clk);
        #1;
        check("held_high_pulses", valid_count - base, 1);
        mult_done = 1'b0;
        repeat (2) @(posedge clk);
        start_vec(0, 200, 0, 117);
        wait_result("second_edge");
        finish_vec();

        // Reset during ALIGN of the R/G pass
        start_vec(255, 1, 0, 76);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun_reset_gray", {24'b0, gray}, 0);
        check("midrun_reset_valid", {31'b0, gray_valid}, 0);
        check("midrun_reset_busy", {31'b0, busy}, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        base = valid_count;
        repeat (100) @(negedge clk);
        #1;
        check("no_start_after_reset", valid_count - base, 0);
        check("idle_after_reset", {31'b0, busy}, 0);
        mult_done = 1'b0;
        repeat (2) @(posedge clk);

        // Enable stall: latency grows by the stall length, result unchanged
        start_vec(128, 64, 32, 79);
        wait_result("lat_ref");
        lat1 = last_valid_cycle - start_cycle;
        finish_vec();
        start_vec(128, 64, 32, 79);
        repeat (6) @(posedge clk);
        #1;
        en = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        en = 1'b1;
        wait_result("lat_stall");
        lat2 = last_valid_cycle - start_cycle;
        finish_vec();
        check("stall_latency_delta", lat2 - lat1, 10);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fp_gray_sum.md
# fp_gray_sum

Downstream stage of `booth_mult` in the grayscale path.
- Takes the three normalized 24-bit mantissa products (R, G, B), their leading-zero shift counts, and the pixel-float exponents.
- Rebuilds the three single-precision products and sums them with an iterative align/add/normalize datapath.
- Converts the sum to an 8-bit gray pixel, rounded half-up and saturated.
- Started by the multiplier's done level; delivers one gray pixel per start.

## Interface
Parameters:
- RED_CONSTANT, 32'h3e99096c, IEEE754 red weight; must equal the multiplier's value.
- GREEN_CONSTANT, 32'h3f1645a2, green weight.
- BLUE_CONSTANT, 32'h3de978d5, blue weight.
- PIXEL_WIDTH, 8, output pixel width.
- MANTISSA_WIDTH, 23, fraction bits.
- EXPONENT_WIDTH, 8, exponent bits.
- BIAS, 127, exponent bias.

Ports:
- clk_i_gray_sum  in  1  clock; the block has one clock.
- rstn_i_gray_sum  in  1  reset, asynchronous, active-low.
- en_i_gray_sum  in  1  when low, all state and outputs hold.
- mult_done_i  in  1  multiplier done level (sticky high).
- mant_R_i / mant_G_i / mant_B_i  in  24 each  normalized product mantissa, bit 23 = hidden 1.
- shift_R_i / shift_G_i / shift_B_i  in  5 each  multiplier significant_exponent (0 or 1 for nonzero inputs).
- pix_exp_R_i / pix_exp_G_i / pix_exp_B_i  in  8 each  biased exponent of the pixel float.
- pix_zero_R_i / pix_zero_G_i / pix_zero_B_i  in  1 each  pixel value is 0; that channel product is 0.
- gray_o  out  8  result; reset 0; holds last result.
- gray_valid_o  out  1  one-cycle pulse with a new gray_o; reset 0.
- busy_o  out  1  high from capture through the valid pulse; reset 0.

## Operation
- **Start:** a registered rising edge of mult_done_i while IDLE captures all inputs. mult_done_i staying high never re-triggers. An edge while busy is ignored.
- **Product exponent** (signed 10-bit, unbiased): E_c = pix_exp_c + K_c[30:23] − 2·BIAS + 1 − shift_c.
- **Product mantissa:** M_c = mant_c, value M_c·2^(E_c−23).
- **Zero channel:** M = 0 and the channel is skipped in ALIGN.
- **Accumulator:** 25-bit mantissa (acc_m) plus exponent (acc_e).

States:
- **IDLE:** waits for start.
- **LOAD:** computes E_R/E_G/E_B; acc ← R product; operand ← G.
- **ALIGN:** one right shift per cycle of the operand with the smaller exponent; its exponent +1. Shifted-out bits are dropped. When the exponents are equal, go to ADD. When the difference is > 24, the smaller operand is treated as 0 immediately.
- **ADD:** acc_m ← acc_m + op_m (both positive, no subtract).
- **NORM:** if acc_m[24] = 1, shift right 1 and acc_e + 1. Then:
  - after the G pass, operand ← B and go to ALIGN;
  - after the B pass, go to TOINT.
- **TOINT:**
  - If acc_e ≥ 8: result = 255.
  - If acc_e < −1 or acc_m = 0: result = 0.
  - Otherwise shift acc_m right one bit per cycle, (23 − acc_e) times, keeping the last bit out as the round bit. Result = acc_m[7:0] + round, saturated to 255.
- **DONE:** gray_o ← result, gray_valid_o = 1 for one cycle, return to IDLE.
- **All channels zero:** the block reaches DONE with gray_o = 0.

## Timing
- Capture on the cycle after the mult_done_i edge is seen. LOAD takes 1 cycle.
- Each pass: ALIGN takes 0–24 cycles, ADD 1, NORM 1.
- TOINT takes ≤ 24 cycles plus 1 round cycle. DONE takes 1.
- Worst-case latency from capture to gray_valid_o is ≤ 80 cycles, counting only enabled cycles.
- en_i_gray_sum low freezes the FSM, counters and outputs. gray_valid_o is held too and may therefore stretch.
- Reset mid-operation: all outputs go to 0 and the FSM to IDLE immediately. A mult_done_i still high after reset is not treated as an edge; the edge register resets to 1.

## Structure
- Package `gray_sum_pkg`: state enum (IDLE, LOAD, ALIGN, ADD, NORM, TOINT, DONE), default constant values, BIAS, acc widths (25/10).
- Sub-module `fp_add_iter`: iterative align/add/normalize of two positive floats with start/done. Instantiated once and used for both passes; the top owns sequencing and TOINT.

## Test plan
- R=G=B=255 (all exponents 134, products from the default constants) → gray_o = 255, one gray_valid_o pulse, busy_o low afterwards.
- R=255, G and B zero flags → gray_o = 76 (76.22); B=255 only → 29 (29.07).
- R=100 only → 30 (29.89, round up); G=200 only → 117 (117.40).
- All zero flags set → gray_o = 0 after DONE, no saturation.
- mult_done_i held high for 200 cycles → exactly one gray_valid_o; a second rising edge → a second result.
- Reset asserted mid-ALIGN → outputs 0, FSM in IDLE; en_i_gray_sum low for 10 cycles mid-run → latency grows by exactly 10 and the result is unchanged.
